// File: rtl/simd_add_sequencer.sv
// Vector add/sub/adc sequencer: walks a VLEN-bit register through one
// MAX_WIDTH-bit simd_adder, one chunk per cycle, with tail and mask merge.
//
// Ports (simd_adder):
//   a, b       chunk operands          sub, rev, carry  operation controls
//   sew        one-hot element width   mask             carry-in bit per lane
//   sum        lane-wise result, carries stop at element boundaries
// Ports (simd_add_sequencer):
//   clk, rst                 clock, synchronous active-high reset
//   valid_i / ready_o        instruction handshake (ready_o = IDLE)
//   sub_i, rev_i, carry_i    subtract, swap operands, add-with-carry
//   sew_i, vl_i, vm_i        element width, element count, unmasked flag
//   mask_i                   per-element mask / carry bits
//   opA_i, opB_i, old_vd_i   operands and prior destination
//   valid_o / ready_i        result handshake (valid_o = DONE)
//   result_o                 merged destination register

module simd_adder #(
    parameter int MIN_WIDTH = 8,
    parameter int MAX_WIDTH = 64,
    parameter int SEW_WIDTH = $clog2(MAX_WIDTH/MIN_WIDTH)+1,
    parameter int LANES     = MAX_WIDTH/MIN_WIDTH
)(
    input  logic [MAX_WIDTH-1:0] a,
    input  logic [MAX_WIDTH-1:0] b,
    input  logic                 sub,
    input  logic                 rev,
    input  logic                 carry,
    input  logic [SEW_WIDTH-1:0] sew,
    input  logic [LANES-1:0]     mask,
    output logic [MAX_WIDTH-1:0] sum
);
    localparam int SW = (SEW_WIDTH > 1) ? $clog2(SEW_WIDTH) : 1;

    logic [SW-1:0] s;
    logic          c;

    always_comb begin
        s   = '0;
        c   = 1'b0;
        sum = '0;
        for (int k = 0; k < SEW_WIDTH; k++)
            if (sew[k]) s = SW'(SEW_WIDTH-1-k);
        for (int j = 0; j < LANES; j++) begin
            logic [MIN_WIDTH-1:0] x;
            logic [MIN_WIDTH-1:0] y;
            logic [MIN_WIDTH:0]   lane;
            logic                 base;
            logic                 cin;
            x = rev ? b[j*MIN_WIDTH +: MIN_WIDTH] : a[j*MIN_WIDTH +: MIN_WIDTH];
            y = rev ? a[j*MIN_WIDTH +: MIN_WIDTH] : b[j*MIN_WIDTH +: MIN_WIDTH];
            if (sub) y = ~y;
            base = (j & ((1 << s) - 1)) == 0;
            // Element base lane restarts the chain: +m for adc,
            // +(1-m) for sbc, +1 for plain subtract.
            cin  = base ? (sub ^ (carry & mask[j])) : c;
            lane = {1'b0, x} + {1'b0, y} + (MIN_WIDTH+1)'(cin);
            sum[j*MIN_WIDTH +: MIN_WIDTH] = lane[MIN_WIDTH-1:0];
            c = lane[MIN_WIDTH];
        end
    end
endmodule

module simd_add_sequencer #(
    parameter int MIN_WIDTH = 8,
    parameter int MAX_WIDTH = 64,
    parameter int VLEN      = 256,
    parameter int SEW_WIDTH = $clog2(MAX_WIDTH/MIN_WIDTH)+1,
    parameter int CHUNKS    = VLEN/MAX_WIDTH
)(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              valid_i,
    output logic                              ready_o,
    input  logic                              sub_i,
    input  logic                              rev_i,
    input  logic                              carry_i,
    input  logic [SEW_WIDTH-1:0]              sew_i,
    input  logic [$clog2(VLEN/MIN_WIDTH):0]   vl_i,
    input  logic                              vm_i,
    input  logic [VLEN/MIN_WIDTH-1:0]         mask_i,
    input  logic [VLEN-1:0]                   opA_i,
    input  logic [VLEN-1:0]                   opB_i,
    input  logic [VLEN-1:0]                   old_vd_i,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic [VLEN-1:0]                   result_o
);
    localparam int LANES     = MAX_WIDTH/MIN_WIDTH;
    localparam int LOG_LANES = $clog2(LANES);
    localparam int TOT_LANES = VLEN/MIN_WIDTH;
    localparam int TL_W      = $clog2(TOT_LANES);
    localparam int VL_W      = TL_W+1;
    localparam int CNT_W     = $clog2(CHUNKS+1);
    localparam int SW        = (SEW_WIDTH > 1) ? $clog2(SEW_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   sub_q, rev_q, carry_q, vm_q;
    logic [SEW_WIDTH-1:0]   sew_q;
    logic [SW-1:0]          s_q;
    logic [VL_W-1:0]        vl_eff_q;
    logic [CNT_W-1:0]       n_q, cnt_q;
    logic [TOT_LANES-1:0]   mask_q;
    logic [VLEN-1:0]        opa_q, opb_q;

    // Accept-time decode; s is log2(lanes per element).
    logic [SW-1:0]          s_in;
    logic [VL_W-1:0]        vlmax, vl_eff_in, lanes_in;
    logic [VL_W:0]          n_tmp;
    logic [CNT_W-1:0]       n_in;

    always_comb begin
        s_in = '0;
        for (int k = 0; k < SEW_WIDTH; k++)
            if (sew_i[k]) s_in = SW'(SEW_WIDTH-1-k);
        vlmax     = VL_W'(TOT_LANES) >> s_in;
        vl_eff_in = (vl_i < vlmax) ? vl_i : vlmax;
        lanes_in  = vl_eff_in << s_in;
        n_tmp     = {1'b0, lanes_in} + (VL_W+1)'(LANES-1);
        n_in      = CNT_W'(n_tmp >> LOG_LANES);
    end

    // Per-lane adder mask and write enable for the current chunk.
    logic [LANES-1:0]     amask, we;
    logic [MAX_WIDTH-1:0] ca, cb, sum;

    always_comb begin
        amask = '0;
        we    = '0;
        ca    = opa_q[cnt_q*MAX_WIDTH +: MAX_WIDTH];
        cb    = opb_q[cnt_q*MAX_WIDTH +: MAX_WIDTH];
        for (int j = 0; j < LANES; j++) begin
            logic [TL_W-1:0] gl;
            logic [TL_W-1:0] elem;
            gl       = TL_W'(cnt_q * LANES + j);
            elem     = gl >> s_q;
            amask[j] = ((gl & TL_W'((1 << s_q) - 1)) == '0) & mask_q[elem];
            we[j]    = ({1'b0, elem} < vl_eff_q) &&
                       (vm_q || mask_q[elem] || carry_q);
        end
    end

    simd_adder #(
        .MIN_WIDTH (MIN_WIDTH),
        .MAX_WIDTH (MAX_WIDTH),
        .SEW_WIDTH (SEW_WIDTH),
        .LANES     (LANES)
    ) u_adder (
        .a     (ca),
        .b     (cb),
        .sub   (sub_q),
        .rev   (rev_q),
        .carry (carry_q),
        .sew   (sew_q),
        .mask  (amask),
        .sum   (sum)
    );

    logic last;
    assign last    = (cnt_q == CNT_W'(n_q - 1'b1));
    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (valid_i) state_d = (n_in == '0) ? DONE : BUSY;
            BUSY: if (last)    state_d = DONE;
            DONE: if (ready_i) state_d = IDLE;
            default:           state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_o <= '0;
            cnt_q    <= '0;
            n_q      <= '0;
            sub_q    <= 1'b0;
            rev_q    <= 1'b0;
            carry_q  <= 1'b0;
            vm_q     <= 1'b0;
            sew_q    <= '0;
            s_q      <= '0;
            vl_eff_q <= '0;
            mask_q   <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
        end else if (state_q == IDLE && valid_i) begin
            result_o <= old_vd_i;
            cnt_q    <= '0;
            n_q      <= n_in;
            sub_q    <= sub_i;
            rev_q    <= rev_i;
            carry_q  <= carry_i;
            vm_q     <= vm_i;
            sew_q    <= sew_i;
            s_q      <= s_in;
            vl_eff_q <= vl_eff_in;
            mask_q   <= mask_i;
            opa_q    <= opA_i;
            opb_q    <= opB_i;
        end else if (state_q == BUSY) begin
            for (int j = 0; j < LANES; j++)
                if (we[j])
                    result_o[cnt_q*MAX_WIDTH + j*MIN_WIDTH +: MIN_WIDTH]
                        <= sum[j*MIN_WIDTH +: MIN_WIDTH];
            // Counter parks on the last chunk so the select stays in range.
            if (!last) cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_simd_add_sequencer.sv
// Scoreboard bench for simd_add_sequencer: directed vectors push expected
// results and latencies; a negedge monitor pops on each result handshake.

module tb_simd_add_sequencer;
    localparam int VLEN = 256;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            valid_i = 1'b0;
    logic            ready_o;
    logic            sub_i = 1'b0;
    logic            rev_i = 1'b0;
    logic            carry_i = 1'b0;
    logic [3:0]      sew_i = 4'b1000;
    logic [5:0]      vl_i = '0;
    logic            vm_i = 1'b1;
    logic [31:0]     mask_i = '0;
    logic [VLEN-1:0] opA_i = '0;
    logic [VLEN-1:0] opB_i = '0;
    logic [VLEN-1:0] old_vd_i = '0;
    logic            valid_o;
    logic            ready_i = 1'b1;
    logic [VLEN-1:0] result_o;

    simd_add_sequencer #(
        .MIN_WIDTH (8),
        .MAX_WIDTH (64),
        .VLEN      (VLEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .sub_i    (sub_i),
        .rev_i    (rev_i),
        .carry_i  (carry_i),
        .sew_i    (sew_i),
        .vl_i     (vl_i),
        .vm_i     (vm_i),
        .mask_i   (mask_i),
        .opA_i    (opA_i),
        .opB_i    (opB_i),
        .old_vd_i (old_vd_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VLEN-1:0] res;
        int              lat;
        int              acc;
        string           name;
    } exp_t;

    exp_t sb[$];
    int   cmp_n = 0;
    int   err_n = 0;
    int   cyc = 0;
    bit   seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && valid_o) begin
            if (sb.size() == 0) begin
                cmp_n++;
                err_n++;
                $display("FAIL unexpected_valid: got valid_o=1 required 0");
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    cmp_n++;
                    if (cyc - sb[0].acc != sb[0].lat) begin
                        err_n++;
                        $display("FAIL %s latency: got %0d required %0d",
                                 sb[0].name, cyc - sb[0].acc, sb[0].lat);
                    end
                end
                if (ready_i) begin
                    cmp_n++;
                    if (result_o !== sb[0].res) begin
                        err_n++;
                        $display("FAIL %s result: got %h required %h",
                                 sb[0].name, result_o, sb[0].res);
                    end
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    function automatic logic [VLEN-1:0] rep64(input logic [63:0] x);
        return {4{x}};
    endfunction

    task automatic chk(input string name, input logic [VLEN-1:0] act,
                       input logic [VLEN-1:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic issue(input string name, input logic s, input logic r,
                         input logic c, input logic [3:0] sew,
                         input logic [5:0] vl, input logic vm,
                         input logic [31:0] m, input logic [VLEN-1:0] a,
                         input logic [VLEN-1:0] b,
                         input logic [VLEN-1:0] old,
                         input logic [VLEN-1:0] exp, input int lat,
                         input bit push);
        exp_t e;
        bit   ok;
        @(posedge clk);
        #1;
        sub_i = s; rev_i = r; carry_i = c; sew_i = sew; vl_i = vl;
        vm_i = vm; mask_i = m; opA_i = a; opB_i = b; old_vd_i = old;
        valid_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (ready_o) ok = 1'b1;
        end
        if (!ok) begin
            cmp_n++;
            err_n++;
            $display("FAIL %s accept: got ready_o=0 required 1", name);
        end else if (push) begin
            e.res = exp; e.lat = lat; e.acc = cyc + 1; e.name = name;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 valid_i = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            cmp_n++;
            err_n++;
            $display("FAIL %s drain: got %0d pending required 0",
                     name, sb.size());
            sb.delete();
            seen = 1'b0;
        end
    endtask

    logic [VLEN-1:0] e16, estall, held;
    bit              got;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", {255'b0, ready_o}, 256'h1);
        chk("reset_valid", {255'b0, valid_o}, 256'h0);
        chk("reset_result", result_o, '0);
        @(posedge clk);
        #1 rst = 1'b0;

        issue("add8_full", 0, 0, 0, 4'b1000, 6'd32, 1, '0,
              {32{8'hFF}}, {32{8'h01}}, {32{8'h5A}}, '0, 4, 1);
        drain("add8_full");

        issue("sub64", 1, 0, 0, 4'b0001, 6'd4, 1, '0,
              rep64(64'd5), rep64(64'd7), '0,
              rep64(64'hFFFF_FFFF_FFFF_FFFE), 4, 1);
        drain("sub64");

        issue("rsub64", 1, 1, 0, 4'b0001, 6'd4, 1, '0,
              rep64(64'd5), rep64(64'd7), '0, rep64(64'd2), 4, 1);
        drain("rsub64");

        issue("tail64", 0, 0, 0, 4'b0001, 6'd3, 1, '0,
              rep64(64'd1), rep64(64'd2), {32{8'hAA}},
              {64'hAAAA_AAAA_AAAA_AAAA, 64'd3, 64'd3, 64'd3}, 3, 1);
        drain("tail64");

        issue("mask32", 0, 0, 0, 4'b0010, 6'd8, 0, 32'hAA,
              {8{32'h1}}, {8{32'h1}}, '0,
              rep64({32'h2, 32'h0}), 4, 1);
        drain("mask32");

        issue("carry16", 0, 0, 1, 4'b0100, 6'd16, 0, 32'h1,
              '0, '0, {32{8'h55}}, 256'h1, 4, 1);
        drain("carry16");

        e16 = {32{8'hCC}};
        for (int i = 0; i < 5; i++) e16[i*16 +: 16] = 16'h0100;
        issue("add16_tail", 0, 0, 0, 4'b0100, 6'd5, 1, '0,
              {16{16'h00FF}}, {16{16'h0001}}, {32{8'hCC}}, e16, 2, 1);
        drain("add16_tail");

        issue("vl_zero", 0, 0, 0, 4'b1000, 6'd0, 1, '0,
              {32{8'h11}}, {32{8'h22}}, {8{32'hDEADBEEF}},
              {8{32'hDEADBEEF}}, 0, 1);
        drain("vl_zero");

        estall = '0;
        for (int i = 0; i < 10; i++) estall[i*8 +: 8] = 8'h32;
        ready_i = 1'b0;
        issue("stall8", 0, 0, 0, 4'b1000, 6'd10, 1, '0,
              {32{8'h10}}, {32{8'h22}}, '0, estall, 2, 1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (valid_o) got = 1'b1;
        end
        chk("stall_valid_seen", {255'b0, got}, 256'h1);
        held = result_o;
        repeat (3) begin
            @(negedge clk);
            chk("stall_result", result_o, held);
            chk("stall_ready", {255'b0, ready_o}, 256'h0);
            chk("stall_valid", {255'b0, valid_o}, 256'h1);
        end
        @(posedge clk);
        #1 ready_i = 1'b1;
        drain("stall8");

        issue("abort", 0, 0, 0, 4'b1000, 6'd32, 1, '0,
              {32{8'h01}}, {32{8'h01}}, {32{8'h77}}, '0, 4, 0);
        @(negedge clk);
        chk("abort_busy_ready", {255'b0, ready_o}, 256'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_ready", {255'b0, ready_o}, 256'h1);
        chk("abort_valid", {255'b0, valid_o}, 256'h0);
        chk("abort_result", result_o, '0);
        @(posedge clk);
        #1 rst = 1'b0;

        issue("clamp64", 0, 0, 0, 4'b0001, 6'd40, 1, '0,
              rep64(64'd1), rep64(64'd1), '0, rep64(64'd2), 4, 1);
        drain("clamp64");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmp_n, err_n);
        $finish;
    end
endmodule
